// File: rtl/sync_ram_arbiter.sv
// rtl/sync_ram_arbiter.sv - two-port round-robin arbiter and sequencer for a single-port synchronous RAM
//
// Purpose:
//   Arbitrates two valid/ready requesters onto one external synchronous RAM.
//   At most one RAM access is issued per cycle. A granted read returns its
//   data on the owning port's response strobe one cycle after the grant edge,
//   taken straight from the RAM's registered dout. Per-port saturating grant
//   counters are kept for bandwidth monitoring.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   arb_en                  arbitration enable; low blocks all new grants
//   req0_* / req1_*         request channels (valid, we, addr, wdata) and ready
//   rsp0_* / rsp1_*         read response strobe and data
//   ram_we/ram_addr/ram_din RAM command, driven combinationally from the winner
//   ram_dout                RAM read data (registered inside the RAM)
//   grant_cnt0/grant_cnt1   saturating per-port grant counts

module sync_ram_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arb_en,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,

    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    // Port that won the most recent grant; the other port wins the next conflict.
    logic last_grant;
    logic gnt0;
    logic gnt1;
    logic arb_live;

    // Grants are also gated by rst_n so nothing is issued to the RAM while
    // reset is held, independent of the state registers.
    always_comb begin
        arb_live = arb_en & rst_n;
        gnt0     = arb_live & req0_valid & (~req1_valid | last_grant);
        gnt1     = arb_live & req1_valid & (~req0_valid | ~last_grant);
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt0) begin
            ram_we   = req0_we;
            ram_addr = req0_addr;
            ram_din  = req0_wdata;
        end else if (gnt1) begin
            ram_we   = req1_we;
            ram_addr = req1_addr;
            ram_din  = req1_wdata;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // The RAM registers dout on the grant edge, so in the response cycle its
    // output already holds the requested word; no extra pipeline stage needed.
    assign rsp0_rdata = ram_dout;
    assign rsp1_rdata = ram_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            rsp0_valid <= gnt0 & ~req0_we;
            rsp1_valid <= gnt1 & ~req1_we;

            if (gnt0) begin
                last_grant <= 1'b0;
            end else if (gnt1) begin
                last_grant <= 1'b1;
            end

            if (gnt0 && (grant_cnt0 != {CNT_W{1'b1}})) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (gnt1 && (grant_cnt1 != {CNT_W{1'b1}})) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule
